// File: rtl/fxp_div_pkg.sv
// Shared state type and sizing helpers for the fixed-point divider.
package fxp_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINAL,
        DONE
    } state_t;

    function automatic int unsigned calc_nw(input int unsigned d_width, input int unsigned q_bits);
        return d_width + q_bits;
    endfunction

    function automatic int unsigned calc_cw(input int unsigned nw);
        return $clog2(nw);
    endfunction

endpackage

// File: rtl/fxp_div_step.sv
// One restoring-division step: shift in a numerator bit, subtract the divisor if it fits.
module fxp_div_step
    import fxp_div_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [W:0]   rem_i,
    input  logic         num_bit_i,
    input  logic [W-1:0] dmag_i,
    output logic [W:0]   rem_o,
    output logic         q_bit_o
);

    logic [W+1:0] trial;
    logic [W+1:0] dext;

    always_comb begin
        trial   = {rem_i, num_bit_i};
        dext    = {2'b00, dmag_i};
        q_bit_o = (trial >= dext);
        // The remainder stays below the divisor, so the top bit is always zero.
        rem_o   = q_bit_o ? (W+1)'(trial - dext) : (W+1)'(trial);
    end

endmodule

// File: rtl/fxp_divider.sv
// Handshaked signed fixed-point divider, one quotient bit per cycle.
// Define FXP_DIVIDE_SAT_EN to clamp out-of-range quotients and report overflow.
module fxp_divider
    import fxp_div_pkg::*;
#(
    parameter int unsigned Q_BITS    = 10,
    parameter int unsigned D_WIDTH   = 32,
    parameter int unsigned TAG_WIDTH = 8,
    parameter int unsigned ROUND     = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [D_WIDTH-1:0]   dividend,
    input  logic [D_WIDTH-1:0]   divisor,
    input  logic [TAG_WIDTH-1:0] tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [D_WIDTH-1:0]   quotient,
    output logic [TAG_WIDTH-1:0] tag_out,
    output logic                 div_by_zero,
    output logic                 overflow
);

    localparam int unsigned NW = calc_nw(D_WIDTH, Q_BITS);
    localparam int unsigned CW = calc_cw(NW);
    localparam logic [CW-1:0]      LAST    = CW'(NW - 1);
    localparam logic [D_WIDTH-1:0] POS_MAX = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic [D_WIDTH-1:0] NEG_MIN = ~POS_MAX;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NW-1:0]        num_q, num_d;
    logic [NW-1:0]        qmag_q, qmag_d;
    logic [D_WIDTH:0]     rem_q, rem_d;
    logic [D_WIDTH-1:0]   dmag_q, dmag_d;
    logic                 neg_q, neg_d;
    logic                 dz_q, dz_d;
    logic                 dvd_neg_q, dvd_neg_d;
    logic                 dvd_zero_q, dvd_zero_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [D_WIDTH-1:0]   quot_q, quot_d;
    logic [TAG_WIDTH-1:0] tag_out_q, tag_out_d;
    logic                 dbz_q, dbz_d;
    logic                 ovf_q, ovf_d;

    logic [D_WIDTH-1:0]   dvd_mag;
    logic [D_WIDTH-1:0]   dvs_mag;
    logic [NW-1:0]        num_init;
    logic [D_WIDTH:0]     step_rem;
    logic                 step_q;

    fxp_div_step #(.W(D_WIDTH)) u_step (
        .rem_i     (rem_q),
        .num_bit_i (num_q[NW-1]),
        .dmag_i    (dmag_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    always_comb begin
        dvd_mag  = dividend[D_WIDTH-1] ? (-dividend) : dividend;
        dvs_mag  = divisor[D_WIDTH-1] ? (-divisor) : divisor;
        num_init = (NW'(dvd_mag) << Q_BITS) + ((ROUND != 0) ? NW'(dvs_mag >> 1) : '0);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        num_d      = num_q;
        qmag_d     = qmag_q;
        rem_d      = rem_q;
        dmag_d     = dmag_q;
        neg_d      = neg_q;
        dz_d       = dz_q;
        dvd_neg_d  = dvd_neg_q;
        dvd_zero_d = dvd_zero_q;
        tag_d      = tag_q;
        quot_d     = quot_q;
        tag_out_d  = tag_out_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    num_d      = num_init;
                    qmag_d     = '0;
                    rem_d      = '0;
                    dmag_d     = dvs_mag;
                    neg_d      = dividend[D_WIDTH-1] ^ divisor[D_WIDTH-1];
                    dz_d       = (divisor == '0);
                    dvd_neg_d  = dividend[D_WIDTH-1];
                    dvd_zero_d = (dividend == '0);
                    tag_d      = tag_in;
                    // A zero divisor runs only the final step, giving a two-edge latency.
                    cnt_d      = (divisor == '0) ? LAST : '0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                rem_d  = step_rem;
                num_d  = num_q << 1;
                qmag_d = {qmag_q[NW-2:0], step_q};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = FINAL;
                end
            end
            FINAL: begin
                tag_out_d = tag_q;
                dbz_d     = dz_q;
                ovf_d     = 1'b0;
                if (dz_q) begin
                    quot_d = dvd_zero_q ? '0 : (dvd_neg_q ? NEG_MIN : POS_MAX);
                end else begin
                    quot_d = D_WIDTH'(neg_q ? (-qmag_q) : qmag_q);
`ifdef FXP_DIVIDE_SAT_EN
                    if (qmag_q > (NW'(POS_MAX) + NW'(neg_q))) begin
                        quot_d = neg_q ? NEG_MIN : POS_MAX;
                        ovf_d  = 1'b1;
                    end
`endif
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            num_q      <= '0;
            qmag_q     <= '0;
            rem_q      <= '0;
            dmag_q     <= '0;
            neg_q      <= 1'b0;
            dz_q       <= 1'b0;
            dvd_neg_q  <= 1'b0;
            dvd_zero_q <= 1'b0;
            tag_q      <= '0;
            quot_q     <= '0;
            tag_out_q  <= '0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            num_q      <= num_d;
            qmag_q     <= qmag_d;
            rem_q      <= rem_d;
            dmag_q     <= dmag_d;
            neg_q      <= neg_d;
            dz_q       <= dz_d;
            dvd_neg_q  <= dvd_neg_d;
            dvd_zero_q <= dvd_zero_d;
            tag_q      <= tag_d;
            quot_q     <= quot_d;
            tag_out_q  <= tag_out_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready    = (state_q == IDLE) && !reset;
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign tag_out     = tag_out_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_fxp_divider.sv
// Directed checks of fxp_divider: a rounding instance and a truncating instance in lockstep.
module tb_fxp_divider;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [7:0]  tag_in;

    logic        in_ready,  out_valid,  div_by_zero,  overflow;
    logic [31:0] quotient;
    logic [7:0]  tag_out;
    logic        in_ready_t, out_valid_t, div_by_zero_t, overflow_t;
    logic [31:0] quotient_t;
    logic [7:0]  tag_out_t;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    fxp_divider #(.Q_BITS(10), .D_WIDTH(32), .TAG_WIDTH(8), .ROUND(1)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
        .tag_out(tag_out), .div_by_zero(div_by_zero), .overflow(overflow)
    );

    fxp_divider #(.Q_BITS(10), .D_WIDTH(32), .TAG_WIDTH(8), .ROUND(0)) dut_trunc (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_t),
        .dividend(dividend), .divisor(divisor), .tag_in(tag_in),
        .out_valid(out_valid_t), .out_ready(out_ready), .quotient(quotient_t),
        .tag_out(tag_out_t), .div_by_zero(div_by_zero_t), .overflow(overflow_t)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  tag;
        logic [31:0] q_round;
        logic [31:0] q_trunc;
        logic        dz;
        logic        ov;
        logic [31:0] q_sat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Offer one operation and wait (bounded) for out_valid; lat counts edges after the accept edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [7:0] t,
                          input bit hold_valid, output int lat);
        @(negedge clock);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tag_in   = t;
        @(posedge clock);
        #1;
        in_valid = hold_valid;
        dividend = $urandom;
        divisor  = $urandom;
        tag_in   = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
        chk("in_ready_t_after_handshake", 32'(in_ready_t), 32'd1);
        chk("out_valid_after_handshake", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] exp_r, exp_t;
        logic        exp_ov;

        vecs[0]  = '{32'd1536,      32'd512,       8'h11, 32'd3072,      32'd3072,      1'b0, 1'b0, 32'h0};
        vecs[1]  = '{32'hFFFFF400,  32'd2048,      8'h22, 32'hFFFFFA00,  32'hFFFFFA00,  1'b0, 1'b0, 32'h0};
        vecs[2]  = '{32'd1024,      32'd3072,      8'h33, 32'd341,       32'd341,       1'b0, 1'b0, 32'h0};
        vecs[3]  = '{32'd2048,      32'd3072,      8'h44, 32'd683,       32'd682,       1'b0, 1'b0, 32'h0};
        vecs[4]  = '{32'hFFFFFFFE,  32'd3,         8'h55, 32'hFFFFFD55,  32'hFFFFFD56,  1'b0, 1'b0, 32'h0};
        vecs[5]  = '{32'd0,         32'hFFFFFFF9,  8'h66, 32'd0,         32'd0,         1'b0, 1'b0, 32'h0};
        vecs[6]  = '{32'h80000000,  32'd1024,      8'h77, 32'h80000000,  32'h80000000,  1'b0, 1'b0, 32'h0};
        vecs[7]  = '{32'h7FFFFFFF,  32'h7FFFFFFF,  8'h88, 32'd1024,      32'd1024,      1'b0, 1'b0, 32'h0};
        vecs[8]  = '{32'd1000,      32'd0,         8'h99, 32'h7FFFFFFF,  32'h7FFFFFFF,  1'b1, 1'b0, 32'h0};
        vecs[9]  = '{32'hFFFFFFFB,  32'd0,         8'hAA, 32'h80000000,  32'h80000000,  1'b1, 1'b0, 32'h0};
        vecs[10] = '{32'd0,         32'd0,         8'hBB, 32'd0,         32'd0,         1'b1, 1'b0, 32'h0};
        vecs[11] = '{32'h7FFFFFFF,  32'd1,         8'hCC, 32'hFFFFFC00,  32'hFFFFFC00,  1'b0, 1'b1, 32'h7FFFFFFF};
        vecs[12] = '{32'h80000000,  32'hFFFFFC00,  8'hDD, 32'h80000000,  32'h80000000,  1'b0, 1'b1, 32'h7FFFFFFF};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        tag_in    = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_tag_out", 32'(tag_out), 32'd0);
        chk("reset_div_by_zero", 32'(div_by_zero), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].tag, 1'b0, lat);
            exp_r  = vecs[i].q_round;
            exp_t  = vecs[i].q_trunc;
            exp_ov = 1'b0;
`ifdef FXP_DIVIDE_SAT_EN
            if (vecs[i].ov) begin
                exp_r  = vecs[i].q_sat;
                exp_t  = vecs[i].q_sat;
                exp_ov = 1'b1;
            end
`endif
            chk($sformatf("latency[%0d]", i), 32'(lat), vecs[i].dz ? 32'd2 : 32'd43);
            chk($sformatf("out_valid_t[%0d]", i), 32'(out_valid_t), 32'd1);
            chk($sformatf("quotient[%0d]", i), quotient, exp_r);
            chk($sformatf("quotient_trunc[%0d]", i), quotient_t, exp_t);
            chk($sformatf("tag_out[%0d]", i), 32'(tag_out), 32'(vecs[i].tag));
            chk($sformatf("tag_out_t[%0d]", i), 32'(tag_out_t), 32'(vecs[i].tag));
            chk($sformatf("div_by_zero[%0d]", i), 32'(div_by_zero), 32'(vecs[i].dz));
            chk($sformatf("div_by_zero_t[%0d]", i), 32'(div_by_zero_t), 32'(vecs[i].dz));
            chk($sformatf("overflow[%0d]", i), 32'(overflow), 32'(exp_ov));
            chk($sformatf("overflow_t[%0d]", i), 32'(overflow_t), 32'(exp_ov));
            release_result();
        end

        // Backpressure: result must hold while out_ready is low, even with a new offer pending.
        run_op(32'd1536, 32'd512, 8'h5A, 1'b1, lat);
        chk("bp_latency", 32'(lat), 32'd43);
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            chk($sformatf("bp_out_valid[%0d]", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp_quotient[%0d]", c), quotient, 32'd3072);
            chk($sformatf("bp_tag_out[%0d]", c), 32'(tag_out), 32'h5A);
            chk($sformatf("bp_in_ready[%0d]", c), 32'(in_ready), 32'd0);
        end
        release_result();

        // Abort mid-calculation at counter value 20.
        @(negedge clock);
        in_valid = 1'b1;
        dividend = 32'd12345;
        divisor  = 32'd1024;
        tag_in   = 8'hEE;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_tag_out", 32'(tag_out), 32'd0);
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clock);
            #1;
            if (out_valid || tag_out == 8'hEE) seen++;
        end
        chk("abort_no_result", 32'(seen), 32'd0);

        run_op(32'd4096, 32'd1024, 8'h10, 1'b0, lat);
        chk("post_abort_latency", 32'(lat), 32'd43);
        chk("post_abort_quotient", quotient, 32'd4096);
        chk("post_abort_trunc", quotient_t, 32'd4096);
        chk("post_abort_tag", 32'(tag_out), 32'h10);
        release_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
